// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
// The access FSM encoding and the requester one-hot helper live here.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_HOLD   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker: the requester that did not win last time has priority.
// Purely combinational; the last_grant pointer is owned by the parent.
module mem_rr_pick (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant = ~last_grant;
        if (req_valid[~last_grant]) begin
            grant = ~last_grant;
        end else if (req_valid[last_grant]) begin
            grant = last_grant;
        end
        grant_valid = |req_valid;
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory between two valid/ready requesters, holding mem_start for HOLD
// clocks with write/addr/data registered, then returning a one-cycle response.
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned HOLD   = DEF_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  mem_start,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned CNT_W = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic last_grant_q;
    logic owner_q;
    logic grant;
    logic grant_valid;
    logic accept;
    logic access_last;

    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    mem_rr_pick u_pick (
        .req_valid   (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Ready only in IDLE and only towards the picked (hence valid) requester.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && grant_valid) begin
            req_ready = grant_onehot(grant);
        end
    end

    assign accept      = |(req_valid & req_ready);
    assign access_last = (state_q == ACCESS) && (cnt_q == CNT_LAST);

    assign win_write = grant ? req_write[1] : req_write[0];
    assign win_addr  = grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign win_wdata = grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (access_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                last_grant_q <= grant;
                owner_q      <= grant;
            end
        end
    end

    // Strobe and fields launch on the same edge and are frozen until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_start <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_start <= 1'b1;
            mem_write <= win_write;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
        end else if (access_last) begin
            mem_start <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 2'b00;
            resp_rdata <= '0;
        end else if (access_last) begin
            resp_valid <= grant_onehot(owner_q);
            resp_rdata <= mem_write ? '0 : mem_rdata;
        end else begin
            resp_valid <= 2'b00;
            resp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scenario bench for mem_access_arbiter with a memory model, a round-robin/timing
// reference model and a response scoreboard.
module tb_mem_access_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int HOLD   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_write = 2'b00;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_rdata;
    logic        mem_start;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    mem_access_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .HOLD   (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_start  (mem_start),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        int         who;
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   acc_who[$];
    int   acc_at[$];

    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   active = 0;
    int   acc_cyc = 0;
    bit   lg = 1'b1;
    logic [7:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_start === 1'b1 && mem_write === 1'b1) mem[mem_addr] = mem_wdata;
    end

    function automatic int pick(input logic [1:0] v, input bit l);
        int other = l ? 0 : 1;
        int same  = l ? 1 : 0;
        if (v[other] === 1'b1) return other;
        if (v[same] === 1'b1) return same;
        return -1;
    endfunction

    // Reference timeline: accept at T -> strobe T+1..T+HOLD, response at T+HOLD+1.
    always @(negedge clk) begin
        if (mon_en) begin
            int p;
            logic [1:0] er;
            logic [1:0] ev;
            exp_t e;
            p  = active ? -1 : pick(req_valid, lg);
            er = (p < 0) ? 2'b00 : ((p == 0) ? 2'b01 : 2'b10);
            nvec++;
            if (req_ready !== er) begin
                nfail++;
                $display("FAIL req_ready @%0d: got %b expected %b", cyc, req_ready, er);
            end
            nvec++;
            if ((req_ready & ~req_valid) !== 2'b00) begin
                nfail++;
                $display("FAIL ready_without_valid @%0d: got %b expected 00", cyc,
                         req_ready & ~req_valid);
            end
            if (active && sb.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL scoreboard_empty @%0d: got 0 entries expected 1", cyc);
                active = 0;
            end else if (active && cyc <= acc_cyc + HOLD) begin
                nvec++;
                if ({mem_start, mem_write, mem_addr, mem_wdata, resp_valid} !==
                    {1'b1, sb[0].write, sb[0].addr, sb[0].wdata, 2'b00}) begin
                    nfail++;
                    $display("FAIL access_cycle @%0d: got s%b w%b a%h d%h r%b expected s1 w%b a%h d%h r00",
                             cyc, mem_start, mem_write, mem_addr, mem_wdata, resp_valid,
                             sb[0].write, sb[0].addr, sb[0].wdata);
                end
            end else if (active) begin
                e  = sb.pop_front();
                ev = (e.who == 0) ? 2'b01 : 2'b10;
                nvec++;
                if ({mem_start, resp_valid, resp_rdata} !== {1'b0, ev, e.rdata}) begin
                    nfail++;
                    $display("FAIL response @%0d: got s%b v%b d%h expected s0 v%b d%h",
                             cyc, mem_start, resp_valid, resp_rdata, ev, e.rdata);
                end
                if (e.write) ref_mem[e.addr] = e.wdata;
                active = 0;
            end else begin
                nvec++;
                if ({mem_start, resp_valid, mem_addr, mem_wdata} !==
                    {1'b0, 2'b00, exp_addr, exp_wdata}) begin
                    nfail++;
                    $display("FAIL idle_outputs @%0d: got s%b v%b a%h d%h expected s0 v00 a%h d%h",
                             cyc, mem_start, resp_valid, mem_addr, mem_wdata, exp_addr, exp_wdata);
                end
            end
            if (rst) begin
                active    = 0;
                lg        = 1'b1;
                exp_addr  = '0;
                exp_wdata = '0;
                sb.delete();
            end else if (p >= 0) begin
                e.who   = p;
                e.write = req_write[p];
                e.addr  = req_addr[p*8 +: 8];
                e.wdata = req_wdata[p*8 +: 8];
                e.rdata = e.write ? 8'h00 : ref_mem[e.addr];
                sb.push_back(e);
                active    = 1;
                acc_cyc   = cyc;
                lg        = (p == 1);
                exp_addr  = e.addr;
                exp_wdata = e.wdata;
                acc_who.push_back(p);
                acc_at.push_back(cyc);
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [7:0] a,
                         input logic [7:0] d, output bit ok);
        req_write[i]       = w;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
        req_valid[i]       = 1'b1;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) ok = 1;
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (!active && sb.size() == 0) ok = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        nvec++;
        if ({mem_start, mem_write, mem_addr, mem_wdata, resp_valid, resp_rdata, req_ready} !== '0) begin
            nfail++;
            $display("FAIL reset_state: got s%b w%b a%h d%h v%b r%h rdy%b expected all zero",
                     mem_start, mem_write, mem_addr, mem_wdata, resp_valid, resp_rdata, req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write_r0();
        bit ok;
        issue(0, 1'b1, 8'h42, 8'h5A, ok);
        nvec++;
        if (!ok) begin nfail++; $display("FAIL write_r0_accept: got timeout expected accept"); end
        @(negedge clk);
        nvec++;
        if ({mem_start, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h42, 8'h5A}) begin
            nfail++;
            $display("FAIL write_r0_first: got s%b w%b a%h d%h expected s1 w1 a42 d5a",
                     mem_start, mem_write, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        nvec++;
        if ({mem_start, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h42, 8'h5A}) begin
            nfail++;
            $display("FAIL write_r0_last: got s%b w%b a%h d%h expected s1 w1 a42 d5a",
                     mem_start, mem_write, mem_addr, mem_wdata);
        end
        @(negedge clk);
        nvec++;
        if ({mem_start, resp_valid} !== {1'b0, 2'b01}) begin
            nfail++;
            $display("FAIL write_r0_resp: got s%b v%b expected s0 v01", mem_start, resp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_r1();
        bit ok;
        issue(1, 1'b0, 8'h42, 8'h00, ok);
        nvec++;
        if (!ok) begin nfail++; $display("FAIL read_r1_accept: got timeout expected accept"); end
        @(negedge clk);
        nvec++;
        if ({mem_start, mem_write, mem_addr} !== {1'b1, 1'b0, 8'h42}) begin
            nfail++;
            $display("FAIL read_r1_access: got s%b w%b a%h expected s1 w0 a42",
                     mem_start, mem_write, mem_addr);
        end
        repeat (4) @(negedge clk);
        nvec++;
        if ({resp_valid, resp_rdata} !== {2'b10, 8'h5A}) begin
            nfail++;
            $display("FAIL read_r1_resp: got v%b d%h expected v10 d5a", resp_valid, resp_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_both_alternate();
        int base;
        logic [1:0] r;
        bit ok;
        wait_idle(ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = acc_who.size();
        for (int i = 0; i < 2; i++) begin
            req_write[i]       = 1'($urandom_range(0, 1));
            req_addr[i*8 +: 8]  = 8'($urandom_range(0, 255));
            req_wdata[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
        req_valid = 2'b11;
        for (int k = 0; k < 80 && acc_who.size() < base + 4; k++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (r[i]) begin
                    req_write[i]       = 1'($urandom_range(0, 1));
                    req_addr[i*8 +: 8]  = 8'($urandom_range(0, 255));
                    req_wdata[i*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
        end
        req_valid = 2'b00;
        nvec++;
        if (acc_who.size() < base + 4) begin
            nfail++;
            $display("FAIL both_count: got %0d accepts expected 4", acc_who.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                nvec++;
                if (acc_who[base+j] != (j % 2)) begin
                    nfail++;
                    $display("FAIL both_order[%0d]: got %0d expected %0d", j, acc_who[base+j], j % 2);
                end
            end
            for (int j = 1; j < 4; j++) begin
                nvec++;
                if (acc_at[base+j] - acc_at[base+j-1] != HOLD + 2) begin
                    nfail++;
                    $display("FAIL both_spacing[%0d]: got %0d expected %0d", j,
                             acc_at[base+j] - acc_at[base+j-1], HOLD + 2);
                end
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_back_to_back_r0();
        int base;
        logic [1:0] r;
        bit saw1;
        bit ok;
        saw1 = 0;
        base = acc_who.size();
        req_write[0]    = 1'b1;
        req_addr[7:0]   = 8'h80;
        req_wdata[7:0]  = 8'h11;
        req_valid       = 2'b01;
        for (int k = 0; k < 80 && acc_who.size() < base + 3; k++) begin
            @(negedge clk);
            if (req_ready[1] !== 1'b0) saw1 = 1;
            r = req_ready;
            @(posedge clk);
            #1;
            if (r[0]) begin
                req_write[0]   = ~req_write[0];
                req_addr[7:0]  = req_addr[7:0] + 8'h01;
                req_wdata[7:0] = req_wdata[7:0] + 8'h22;
            end
        end
        req_valid = 2'b00;
        nvec++;
        if (saw1) begin nfail++; $display("FAIL b2b_ready1: got 1 expected never 1"); end
        nvec++;
        if (acc_who.size() < base + 3) begin
            nfail++;
            $display("FAIL b2b_count: got %0d accepts expected 3", acc_who.size() - base);
        end else begin
            for (int j = 0; j < 3; j++) begin
                nvec++;
                if (acc_who[base+j] != 0) begin
                    nfail++;
                    $display("FAIL b2b_who[%0d]: got %0d expected 0", j, acc_who[base+j]);
                end
            end
            for (int j = 1; j < 3; j++) begin
                nvec++;
                if (acc_at[base+j] - acc_at[base+j-1] != HOLD + 2) begin
                    nfail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", j,
                             acc_at[base+j] - acc_at[base+j-1], HOLD + 2);
                end
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_access();
        int base;
        bit ok;
        issue(0, 1'b0, 8'h33, 8'h00, ok);
        nvec++;
        if (!ok) begin nfail++; $display("FAIL rstmid_accept: got timeout expected accept"); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (mem_start !== 1'b1) begin
            nfail++;
            $display("FAIL rstmid_second_cycle: got s%b expected s1", mem_start);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({mem_start, resp_valid} !== {1'b0, 2'b00}) begin
            nfail++;
            $display("FAIL rstmid_abort: got s%b v%b expected s0 v00", mem_start, resp_valid);
        end
        base = acc_who.size();
        req_write      = 2'b00;
        req_addr       = 16'h0201;
        req_valid      = 2'b11;
        for (int k = 0; k < 20 && acc_who.size() == base; k++) begin
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        nvec++;
        if (acc_who.size() == base) begin
            nfail++;
            $display("FAIL rstmid_regrant: got no accept expected requester 0");
        end else if (acc_who[base] != 0) begin
            nfail++;
            $display("FAIL rstmid_regrant: got requester %0d expected 0", acc_who[base]);
        end
        wait_idle(ok);
    endtask

    task automatic test_addr_change();
        bit ok;
        issue(0, 1'b0, 8'h10, 8'h00, ok);
        nvec++;
        if (!ok) begin nfail++; $display("FAIL addr_change_accept: got timeout expected accept"); end
        req_addr[7:0] = 8'h20;
        @(negedge clk);
        nvec++;
        if (mem_addr !== 8'h10) begin
            nfail++;
            $display("FAIL addr_change_early: got %h expected 10", mem_addr);
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (mem_addr !== 8'h10) begin
            nfail++;
            $display("FAIL addr_change_late: got %h expected 10", mem_addr);
        end
        wait_idle(ok);
        @(negedge clk);
        nvec++;
        if (mem_addr !== 8'h10) begin
            nfail++;
            $display("FAIL addr_change_idle_hold: got %h expected 10", mem_addr);
        end
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        test_reset();
        test_write_r0();
        test_read_r1();
        test_both_alternate();
        test_back_to_back_r0();
        test_reset_mid_access();
        test_addr_change();
        wait_idle(ok);
        nvec++;
        if (!ok) begin nfail++; $display("FAIL final_drain: got busy expected idle"); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequencing controller that shares one `memory` instance between two requesters. It converts a valid/ready request from either requester into a race-free memory access cycle: `start` is held for a fixed number of clocks, with `write`, `addr` and `data` registered and stable throughout. It returns read data or a write acknowledge to the requester that was granted. It sits directly in front of `memory` and replaces ad-hoc testbench driving of its strobes.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 8: memory data width.
- `HOLD`, 4: cycles `mem_start` stays high per access; must be ≥1.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: request valid, bit i = requester i.
- `req_ready`  out  2: request accepted this cycle, one-hot or zero.
- `req_write`  in  2: 1 = write, 0 = read, per requester.
- `req_addr`  in  2*ADDR_W: requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  2*DATA_W: packed the same way as `req_addr`.
- `resp_valid`  out  2: one-cycle completion pulse to the owning requester.
- `resp_rdata`  out  DATA_W: read data, valid with `resp_valid`; 0 for writes.
- `mem_start`  out  1: memory start strobe.
- `mem_write`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data.

## Operation
- FSM states:
  - IDLE: `req_ready` may assert.
  - ACCESS: `mem_start`=1, counter runs.
  - DONE: `resp_valid` pulse, `req_ready`=0.
- IDLE→ACCESS on any `req_valid & req_ready`.
- ACCESS→DONE when the hold counter reaches `HOLD`-1.
- DONE→IDLE unconditionally.
- Round-robin arbitration: a 1-bit `last_grant` pointer.
  - The requester ≠ `last_grant` wins if valid; otherwise the other wins if valid.
  - `last_grant` updates on accept.
- `req_ready` is combinational from state, `req_valid` and `last_grant`. It is never high for a requester whose `req_valid`=0.
- On accept, `mem_write`, `mem_addr` and `mem_wdata` register from the winner together with `mem_start`. All four change on the same edge and stay constant through ACCESS.
- Requesters hold `req_valid` and the request fields until `req_ready`.
- A read captures `mem_rdata` on the last ACCESS cycle. A write returns `resp_rdata`=0.
- The hold counter is `$clog2(HOLD+1)` bits and clears on entry to ACCESS.

## Timing
- Reset values:
  - `mem_start`, `mem_write`, `mem_addr`, `mem_wdata`: 0.
  - `resp_valid`, `resp_rdata`: 0.
  - state: IDLE; `last_grant`: 1, so requester 0 wins first.
- Accept at cycle T:
  - `mem_start` is high for cycles T+1 … T+HOLD.
  - `resp_valid` is high at T+HOLD+1 and `mem_start` is 0 from then on.
  - The next accept can happen no earlier than T+HOLD+2.
- Throughput: one access per HOLD+2 cycles.
- Simultaneous valid from both requesters: round-robin decides. With both held continuously, grants alternate 0,1,0,1.
- Address/data/write never change while `mem_start`=1. `mem_addr` and `mem_wdata` keep their last values in IDLE.
- Reset mid-ACCESS or in DONE:
  - Next edge: `mem_start`=0, state IDLE, `last_grant`=1.
  - No `resp_valid` is issued for the aborted access.
- Reset has priority over every other transition.

## Structure
- Shared package `mem_ctrl_pkg`:
  - `state_t` enum (IDLE, ACCESS, DONE).
  - Default `ADDR_W`, `DATA_W` and `HOLD` localparams.
- Optional sub-module `mem_rr_pick`: 2-way round-robin picker.
  - Inputs: `req_valid`, `last_grant`.
  - Outputs: `grant`, `grant_valid`.
  - Purely combinational. The pointer stays in the parent.

## Test plan
- Requester 0 write, addr 0x42, data 0x5A, accepted at cycle T.
  - `mem_start`=1 for T+1…T+4 with `mem_write`=1, `mem_addr`=0x42, `mem_wdata`=0x5A stable.
  - `resp_valid`=2'b01 at T+5.
- Requester 1 read of 0x42 after that write, memory model returning 0x5A → `mem_write`=0 during ACCESS, `resp_valid`=2'b10, `resp_rdata`=0x5A.
- Both requesters valid continuously from reset release → grant order 0,1,0,1, accepts spaced exactly 6 cycles apart (HOLD=4).
- Only requester 0 valid, 3 back-to-back requests → all three go to requester 0, `req_ready[1]` never 1, accepts spaced 6 cycles apart.
- `rst` asserted on the 2nd ACCESS cycle → `mem_start`=0 on the next edge, no `resp_valid`; a subsequent simultaneous request is granted to requester 0.
- Requester changes `req_addr` from 0x10 to 0x20 during ACCESS, after its request was accepted → `mem_addr` stays 0x10 until DONE.
